// File: rtl/dm_access_unit_if.sv
// rtl/dm_access_unit_if.sv - request/response and data-RAM signal bundle for dm_access_unit
//
// Request side : req_valid, req_ready, req_we, req_type, req_addr, req_wdata
// Response side: resp_valid, resp_ready, resp_data, resp_err
// RAM side     : mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
// Modports     : slave  = the access unit itself
//                master = the surroundings (MEM stage plus data RAM)
interface dm_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        input  resp_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        output resp_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - sequential data-memory access unit with split misaligned accesses
//
// Ports: clk, rst (async, active high), bus (dm_access_unit_if.slave):
//   request handshake, response handshake, synchronous byte-enabled RAM port.
// Build option: DM_MISALIGN_EN - when defined, word-crossing accesses are split
//   into two RAM cycles; when undefined they are rejected with resp_err.
module dm_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    dm_access_unit_if.slave         bus
);

`ifdef DM_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, MEM0, MEM1, WAIT, RESP} state_t;

    state_t            state, state_nx;

    logic              we_q;
    logic [2:0]        type_q;
    logic [1:0]        pos_q;
    logic              cross_q;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       resp_data_q;
    logic              resp_err_q;

    // Decode of the request currently offered
    logic [2:0]        in_size;
    logic              in_illegal;
    logic              in_cross;
    logic              in_reject;

    always_comb begin
        in_size    = 3'd0;
        in_illegal = 1'b0;
        case (bus.req_type)
            3'b000:         in_size = 3'd4;
            3'b001, 3'b010: in_size = 3'd2;
            3'b011, 3'b100: in_size = 3'd1;
            default:        in_illegal = 1'b1;
        endcase
    end

    // pos+size never exceeds 7, so three bits hold the sum
    assign in_cross  = (({1'b0, bus.req_addr[1:0]} + in_size) > 3'd4);
    assign in_reject = in_illegal || (in_cross && !MISALIGN_EN);

    // Store lane placement across the two-word window {A+1, A}
    logic [3:0]  size_mask;
    logic [63:0] st_lanes;
    logic [7:0]  st_mask;

    always_comb begin
        case (type_q)
            3'b000:         size_mask = 4'b1111;
            3'b001, 3'b010: size_mask = 4'b0011;
            default:        size_mask = 4'b0001;
        endcase
    end

    assign st_lanes = {32'b0, wdata_q} << {pos_q, 3'b000};
    assign st_mask  = {4'b0, size_mask} << pos_q;

    // Load merge: in WAIT the second (or only) word is on mem_rdata this cycle
    logic [63:0] ld_pair;
    logic [31:0] ld_word;
    logic [31:0] ld_ext;

    assign ld_pair = cross_q ? {bus.mem_rdata, lo_q} : {32'b0, bus.mem_rdata};
    assign ld_word = 32'(ld_pair >> {pos_q, 3'b000});

    always_comb begin
        case (type_q)
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b010:  ld_ext = {16'b0, ld_word[15:0]};
            3'b011:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            type_q      <= 3'b0;
            pos_q       <= 2'b0;
            cross_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'b0;
            lo_q        <= 32'b0;
            resp_data_q <= 32'b0;
            resp_err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        type_q      <= bus.req_type;
                        pos_q       <= bus.req_addr[1:0];
                        cross_q     <= in_cross;
                        addr_q      <= bus.req_addr[ADDR_W-1:2];
                        wdata_q     <= bus.req_wdata;
                        resp_err_q  <= in_reject;
                        resp_data_q <= 32'b0;
                    end
                end
                MEM1: begin
                    if (!we_q) lo_q <= bus.mem_rdata;
                end
                WAIT: begin
                    resp_data_q <= ld_ext;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_err_q  <= 1'b0;
                        resp_data_q <= 32'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.req_valid) state_nx = in_reject ? RESP : MEM0;
            MEM0: begin
                if (cross_q && MISALIGN_EN) state_nx = MEM1;
                else                        state_nx = we_q ? RESP : WAIT;
            end
            MEM1:    state_nx = we_q ? RESP : WAIT;
            WAIT:    state_nx = RESP;
            RESP:    if (bus.resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM port is driven purely from state so reset silences it at once
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'b0;
        case (state)
            MEM0: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = addr_q;
                if (we_q) begin
                    bus.mem_we    = st_mask[3:0];
                    bus.mem_wdata = st_lanes[31:0];
                end
            end
            MEM1: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = addr_q + {{(ADDR_W-3){1'b0}}, 1'b1};
                if (we_q) begin
                    bus.mem_we    = st_mask[7:4];
                    bus.mem_wdata = st_lanes[63:32];
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - directed table-driven bench for dm_access_unit
module tb_dm_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_access_unit_if #(.ADDR_W(32)) bus ();

    dm_access_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous byte-enabled data RAM, 256 words, aliased on the low address bits
    logic [31:0] ram [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) ram[bus.mem_addr[7:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // Log of RAM cycles seen during the current transaction
    logic [29:0] log_addr [$];
    logic [3:0]  log_we   [$];
    logic [31:0] log_wd   [$];
    always @(negedge clk) begin
        if (bus.mem_en) begin
            log_addr.push_back(bus.mem_addr);
            log_we.push_back(bus.mem_we);
            log_wd.push_back(bus.mem_wdata);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_mcyc;
        logic [29:0] exp_maddr;
        logic [3:0]  exp_mwe;
        logic [31:0] exp_mwd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_data,
                                input logic exp_err, input int exp_lat, input int exp_mcyc,
                                input logic [29:0] exp_maddr, input logic [3:0] exp_mwe,
                                input logic [31:0] exp_mwd);
        vec_t v;
        v.we = we; v.typ = typ; v.addr = addr; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_mcyc = exp_mcyc; v.exp_maddr = exp_maddr; v.exp_mwe = exp_mwe; v.exp_mwd = exp_mwd;
        return v;
    endfunction

    // Issue one request, accept the response in its first valid cycle, check everything
    task automatic do_req(input vec_t v, input int idx);
        int          lat;
        logic [31:0] d;
        logic        e;
        log_addr.delete(); log_we.delete(); log_wd.delete();
        chk("req_ready_idle", idx, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_type  = v.typ;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        step;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 12) begin
            step;
            lat++;
        end
        d = bus.resp_data;
        e = bus.resp_err;
        bus.resp_ready = 1'b1;
        step;
        bus.resp_ready = 1'b0;
        chk("latency", idx, 32'(lat), 32'(v.exp_lat));
        chk("resp_data", idx, d, v.exp_data);
        chk("resp_err", idx, 32'(e), 32'(v.exp_err));
        chk("mem_cycles", idx, 32'(log_addr.size()), 32'(v.exp_mcyc));
        if (log_addr.size() > 0 && v.exp_mcyc > 0) begin
            chk("mem_addr0", idx, 32'(log_addr[0]), 32'(v.exp_maddr));
            chk("mem_we0", idx, 32'(log_we[0]), 32'(v.exp_mwe));
            if (v.we) chk("mem_wdata0", idx, log_wd[0], v.exp_mwd);
        end
        chk("req_ready_after", idx, 32'(bus.req_ready), 32'd1);
        chk("resp_valid_after", idx, 32'(bus.resp_valid), 32'd0);
    endtask

    vec_t vecs [$];

    initial begin
        int          lat;
        logic [31:0] held;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_type   = 3'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;

        //        we    typ     addr         wdata         data          err lat mc maddr        mwe      mwdata
        vecs.push_back(mk(1'b1, 3'b000, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1, 30'h40, 4'b1111, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 3'b000, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 3'b011, 32'h102, 32'h00000080, 32'h0,        0, 2, 1, 30'h40, 4'b0100, 32'h00800000));
        vecs.push_back(mk(1'b0, 3'b011, 32'h102, 32'h0,        32'hFFFFFF80, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h102, 32'h0,        32'h00000080, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDE80, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h102, 32'h0,        32'h0000DE80, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h101, 32'h00001234, 32'h0,        0, 2, 1, 30'h40, 4'b0110, 32'h00123400));
        vecs.push_back(mk(1'b0, 3'b000, 32'h100, 32'h0,        32'hDE1234EF, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h101, 32'h0,        32'h00000034, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b111, 32'h100, 32'h0,        32'h0,        1, 1, 0, 30'h0,  4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 3'b101, 32'h100, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 30'h0,  4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h100, 32'h0,        32'hDE1234EF, 0, 3, 1, 30'h40, 4'b0000, 32'h0));
`ifdef DM_MISALIGN_EN
        vecs.push_back(mk(1'b1, 3'b000, 32'h203, 32'h11223344, 32'h0,        0, 3, 2, 30'h80, 4'b1000, 32'h44000000));
        vecs.push_back(mk(1'b0, 3'b000, 32'h203, 32'h0,        32'h11223344, 0, 4, 2, 30'h80, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h203, 32'h0,        32'h00003344, 0, 4, 2, 30'h80, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h203, 32'h0,        32'h00000044, 0, 3, 1, 30'h80, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h202, 32'h0,        32'h00004400, 0, 3, 1, 30'h80, 4'b0000, 32'h0));
`else
        vecs.push_back(mk(1'b0, 3'b001, 32'h203, 32'h0,        32'h0,        1, 1, 0, 30'h0,  4'b0000, 32'h0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h201, 32'h11223344, 32'h0,        1, 1, 0, 30'h0,  4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h202, 32'h0,        32'h0,        0, 3, 1, 30'h80, 4'b0000, 32'h0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h200, 32'h0,        32'h0,        0, 3, 1, 30'h80, 4'b0000, 32'h0));
`endif

        // Reset state
        step; step;
        chk("rst_req_ready", 0, 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 0, 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 0, bus.resp_data, 32'h0);
        chk("rst_resp_err", 0, 32'(bus.resp_err), 32'd0);
        chk("rst_mem_en", 0, 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 0, 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 0, 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 0, bus.mem_wdata, 32'h0);
        rst = 1'b0;
        step;

        foreach (vecs[i]) do_req(vecs[i], i);

`ifdef DM_MISALIGN_EN
        // Word store at the top word address wraps its second half to word 0
        do_req(mk(1'b1, 3'b000, 32'hFFFFFFFD, 32'h55667788, 32'h0, 0, 3, 2,
                  30'h3FFFFFFF, 4'b1110, 32'h66778800), 100);
        if (log_addr.size() == 2) begin
            chk("wrap_addr1", 100, 32'(log_addr[1]), 32'h0);
            chk("wrap_we1", 100, 32'(log_we[1]), 32'h1);
            chk("wrap_wd1", 100, log_wd[1], 32'h00000055);
        end else begin
            chk("wrap_cycles", 100, 32'(log_addr.size()), 32'd2);
        end
`endif

        // Response stall: hold resp_ready low for 5 cycles
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_type  = 3'b000;
        bus.req_addr  = 32'h100;
        step;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 12) begin
            step;
            lat++;
        end
        chk("stall_latency", 200, 32'(lat), 32'd3);
        held = bus.resp_data;
        chk("stall_data", 200, held, 32'hDE1234EF);
        for (int c = 0; c < 5; c++) begin
            step;
            chk("stall_valid", 201 + c, 32'(bus.resp_valid), 32'd1);
            chk("stall_hold", 201 + c, bus.resp_data, 32'hDE1234EF);
            chk("stall_req_ready", 201 + c, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        step;
        bus.resp_ready = 1'b0;
        chk("stall_req_ready_after", 210, 32'(bus.req_ready), 32'd1);
        chk("stall_resp_valid_after", 210, 32'(bus.resp_valid), 32'd0);
        chk("stall_resp_data_after", 210, bus.resp_data, 32'h0);

        // Asynchronous reset in the middle of a store
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_type  = 3'b000;
        bus.req_wdata = 32'hCAFEF00D;
`ifdef DM_MISALIGN_EN
        bus.req_addr  = 32'h203;
        step;
        bus.req_valid = 1'b0;
        step;
        chk("mid_mem_en", 300, 32'(bus.mem_en), 32'd1);
        chk("mid_mem_we", 300, 32'(bus.mem_we), 32'h7);
`else
        bus.req_addr  = 32'h200;
        step;
        bus.req_valid = 1'b0;
        chk("mid_mem_en", 300, 32'(bus.mem_en), 32'd1);
        chk("mid_mem_we", 300, 32'(bus.mem_we), 32'hF);
`endif
        rst = 1'b1;
        #1;
        chk("arst_mem_en", 301, 32'(bus.mem_en), 32'd0);
        chk("arst_mem_we", 301, 32'(bus.mem_we), 32'd0);
        chk("arst_mem_addr", 301, 32'(bus.mem_addr), 32'd0);
        chk("arst_req_ready", 301, 32'(bus.req_ready), 32'd1);
        chk("arst_resp_valid", 301, 32'(bus.resp_valid), 32'd0);
        #3;
        rst = 1'b0;
        step;
        chk("post_rst_req_ready", 302, 32'(bus.req_ready), 32'd1);
        chk("post_rst_resp_valid", 302, 32'(bus.resp_valid), 32'd0);
        chk("post_rst_mem_en", 302, 32'(bus.mem_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Sequential data-memory access unit between the MEM stage and a synchronous byte-enabled data RAM. It replaces the combinational lane shifter with a request/response engine that splits word-crossing loads and stores into two RAM cycles. It also merges, shifts and sign/zero-extends load data, and flags unsupported accesses.

## Interface
- ADDR_W, 32: byte-address width; RAM word address is ADDR_W-2 bits, wraps modulo 2^(ADDR_W-2).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  unit idle, can accept; equals (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_type  in  3  000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned; 101-111 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  request rejected, no RAM access made.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  4  byte-lane write enables; 0 for reads.
- mem_addr  out  ADDR_W-2  RAM word address.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data, valid the cycle after a read with mem_en=1.

## Operation
- Size: word 4 bytes, halfword types 2, byte types 1. pos = req_addr[1:0]. A = req_addr[ADDR_W-1:2]. cross = pos+size > 4.
- Reset: state IDLE; resp_valid=0, resp_data=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; req_ready=1 once in IDLE.
- IDLE: on req_valid, latch request, compute pos/cross.
  - Illegal type, or cross with misalign disabled: go to RESP with resp_err=1, resp_data=0.
  - Otherwise go to MEM0.
- Store lanes: S = {32'b0, req_wdata} << 8*pos. M = {4'b0, size mask} << pos, where size mask is 1111, 0011 or 0001.
- MEM0: mem_en=1, mem_addr=A. Stores drive mem_we=M[3:0], mem_wdata=S[31:0]. Loads drive mem_we=0.
  - Next state: MEM1 if cross; else WAIT for a load, RESP for a store.
- MEM1: mem_en=1, mem_addr=A+1 (wrapping). Stores drive mem_we=M[7:4], mem_wdata=S[63:32]. Loads capture mem_rdata into lo.
  - Next state: WAIT for a load, RESP for a store.
- WAIT (loads only): capture mem_rdata into lo if non-crossing, into hi if crossing. Register resp_data = extend(({hi,lo} >> 8*pos)[31:0]).
  - Sign-extend halfword/byte types; zero-extend unsigned types.
  - Next state: RESP.
- RESP: resp_valid=1. On resp_ready, go to IDLE and clear resp_valid, resp_err and resp_data.
- mem_en, mem_we, mem_addr and mem_wdata are 0 in IDLE, WAIT and RESP.
- Only one request is outstanding; req_ready=0 outside IDLE.

## Timing
- Request accepted in cycle T0. Latency is counted to the first cycle resp_valid=1:
  - error: T1;
  - store: T2 (non-crossing), T3 (crossing);
  - load: T3 (non-crossing), T4 (crossing).
- Back-to-back: if resp_ready=1 in the first RESP cycle, the next request can be accepted the following cycle.
- Response stalls indefinitely while resp_ready=0; all response outputs are stable during the stall.
- Asynchronous rst mid-operation: abort immediately, return to IDLE, force all outputs to reset values; a split store may be left half-written.
- A word access at the top word address, with pos!=0, wraps its second access to word 0.

## Configuration
- DM_MISALIGN_EN defined: crossing accesses are split into two RAM cycles as above.
- DM_MISALIGN_EN undefined:
  - MEM1 is unreachable.
  - Any crossing request (halfword at pos 3, word at pos 1-3) returns resp_err=1 at T1, with no RAM access.
  - Non-crossing behaviour is unchanged.

## Test plan
- Aligned word store 0xDEADBEEF to 0x100, then load word from 0x100.
  - Store: MEM0 has mem_addr=0x40, mem_we=1111; resp at T2.
  - Load: resp_data=0xDEADBEEF at T3, resp_err=0.
- Store byte 0x80 to 0x102 (pos 2), then load byte from 0x102 -> mem_we=0100, mem_wdata=0x00800000; lb returns 0xFFFFFF80, lbu returns 0x00000080.
- With DM_MISALIGN_EN: word 0x11223344 stored at 0x203, then loaded.
  - Store cycles: word 0x80 with mem_we=1000, mem_wdata=0x44000000; word 0x81 with mem_we=0111, mem_wdata=0x00112233.
  - Load returns 0x11223344 at T4.
- Without DM_MISALIGN_EN: lh from 0x203 -> resp_err=1, resp_data=0 at T1, mem_en never asserted.
- req_type=111 -> resp_err=1 at T1, no RAM access.
- Hold resp_ready=0 for 5 cycles, then assert -> resp_valid and resp_data stable throughout; req_ready=1 the cycle after acceptance.
- Assert rst during MEM1 of a split store -> mem_en=0 immediately; req_ready=1 and resp_valid=0 after reset.
